// File: rtl/reg_file_sb.sv
// Multi-read-port, dual-write-port register file with a per-register busy
// scoreboard; reads bypass same-cycle writes, port B has write priority.
module reg_file_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wa_en,
    input  logic [AW-1:0]       wa_addr,
    input  logic [XLEN-1:0]     wa_data,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                mark_en,
    input  logic [AW-1:0]       mark_addr,
    output logic [NREGS-1:0]    busy_vec,
    output logic                wr_collision
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] busy_next;
    logic             wa_ok;
    logic             wb_ok;
    logic             collision_next;

    assign wa_ok = wa_en && !(ZERO_REG != 0 && wa_addr == '0);
    assign wb_ok = wb_en && !(ZERO_REG != 0 && wb_addr == '0);
    assign collision_next = wa_en && wb_en && (wa_addr == wb_addr)
                          && !(ZERO_REG != 0 && wa_addr == '0);

    // A new issue (set) outranks a completion (clear) on the same register.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (mark_en) set_vec[mark_addr] = 1'b1;
        if (wb_en)   clr_vec[wb_addr]   = 1'b1;
        busy_next = (busy_vec & ~clr_vec) | set_vec;
        if (ZERO_REG != 0) busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            busy_vec     <= '0;
            wr_collision <= 1'b0;
        end else begin
            // Port B is applied last so it wins a same-address write.
            if (wa_ok) regs[wa_addr] <= wa_data;
            if (wb_ok) regs[wb_addr] <= wb_data;
            busy_vec     <= busy_next;
            wr_collision <= collision_next;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;
        logic            zero_hit;
        logic            wb_hit;
        logic            mark_hit;

        assign addr     = rd_addr[i*AW +: AW];
        assign zero_hit = (ZERO_REG != 0) && (addr == '0);
        assign wb_hit   = wb_en && (wb_addr == addr);
        assign mark_hit = mark_en && (mark_addr == addr);

        // Checks are ordered lowest priority first; the last match wins.
        always_comb begin
            data = regs[addr];
            if (wa_en && wa_addr == addr) data = wa_data;
            if (wb_hit)                   data = wb_data;
            if (zero_hit)                 data = '0;
            busy = busy_vec[addr];
            if (wb_hit && !mark_hit)      busy = 1'b0;
            if (zero_hit)                 busy = 1'b0;
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_busy[i]              = busy;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed-vector bench for reg_file_sb: default configuration plus a
// narrow four-read-port instance with an ordinary register 0.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset_n;

    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wa_en, wb_en, mark_en;
    logic [4:0]  wa_addr, wb_addr, mark_addr;
    logic [31:0] wa_data, wb_data;
    logic [31:0] busy_vec;
    logic        wr_collision;

    logic [11:0] p_rd_addr;
    logic [63:0] p_rd_data;
    logic [3:0]  p_rd_busy;
    logic        p_wa_en, p_wb_en, p_mark_en;
    logic [2:0]  p_wa_addr, p_wb_addr, p_mark_addr;
    logic [15:0] p_wa_data, p_wb_data;
    logic [7:0]  p_busy_vec;
    logic        p_wr_collision;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk(clk), .reset_n(reset_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .mark_en(mark_en), .mark_addr(mark_addr),
        .busy_vec(busy_vec), .wr_collision(wr_collision)
    );

    reg_file_sb #(.XLEN(16), .NREGS(8), .NRD(4), .ZERO_REG(0)) dut_p (
        .clk(clk), .reset_n(reset_n),
        .rd_addr(p_rd_addr), .rd_data(p_rd_data), .rd_busy(p_rd_busy),
        .wa_en(p_wa_en), .wa_addr(p_wa_addr), .wa_data(p_wa_data),
        .wb_en(p_wb_en), .wb_addr(p_wb_addr), .wb_data(p_wb_data),
        .mark_en(p_mark_en), .mark_addr(p_mark_addr),
        .busy_vec(p_busy_vec), .wr_collision(p_wr_collision)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wa_en = 0; wb_en = 0; mark_en = 0;
        wa_addr = '0; wb_addr = '0; mark_addr = '0;
        wa_data = '0; wb_data = '0;
        p_wa_en = 0; p_wb_en = 0; p_mark_en = 0;
        p_wa_addr = '0; p_wb_addr = '0; p_mark_addr = '0;
        p_wa_data = '0; p_wb_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rd_addr = '0;
        p_rd_addr = '0;
        reset_n = 0;
        #12;
        check("rst_busy", 64'(busy_vec), 64'h0);
        check("rst_coll", 64'(wr_collision), 64'h0);
        reset_n = 1;
        tick();

        // Reset mid-operation: data, pending busy bit and collision flag all drop
        wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF;
        wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
        mark_en = 1; mark_addr = 6;
        tick();
        idle();
        rd_addr[4:0] = 5;
        #1;
        check("pre_rst_data", 64'(rd_data[31:0]), 64'hDEADBEEF);
        check("pre_rst_busy", 64'(busy_vec), 64'h40);
        check("pre_rst_coll", 64'(wr_collision), 64'h1);
        reset_n = 0;
        #1;
        check("rst_data5", 64'(rd_data[31:0]), 64'h0);
        check("rst_busy_mid", 64'(busy_vec), 64'h0);
        check("rst_coll_mid", 64'(wr_collision), 64'h0);
        #2;
        reset_n = 1;
        tick();

        // Same-cycle bypass from port A, then the stored value
        wa_en = 1; wa_addr = 7; wa_data = 32'h12345678;
        rd_addr[4:0] = 7;
        #1;
        check("bypass_a", 64'(rd_data[31:0]), 64'h12345678);
        tick();
        idle();
        #1;
        check("stored_a", 64'(rd_data[31:0]), 64'h12345678);

        // Register 0 stays zero and never busy
        wa_en = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF;
        wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF;
        mark_en = 1; mark_addr = 0;
        rd_addr[4:0] = 0;
        #1;
        check("zero_bypass", 64'(rd_data[31:0]), 64'h0);
        check("zero_rdbusy", 64'(rd_busy[0]), 64'h0);
        tick();
        idle();
        #1;
        check("zero_data", 64'(rd_data[31:0]), 64'h0);
        check("zero_busyvec", 64'(busy_vec[0]), 64'h0);
        check("zero_coll", 64'(wr_collision), 64'h0);

        // Scoreboard: mark, same-cycle completion, mark+completion, WAW
        mark_en = 1; mark_addr = 9;
        rd_addr[9:5] = 9;
        tick();
        idle();
        #1;
        check("mark9_vec", 64'(busy_vec), 64'h200);
        check("mark9_rdbusy", 64'(rd_busy[1]), 64'h1);
        wb_en = 1; wb_addr = 9; wb_data = 32'hA5A5A5A5;
        #1;
        check("wb9_rdbusy", 64'(rd_busy[1]), 64'h0);
        check("wb9_bypass", 64'(rd_data[63:32]), 64'hA5A5A5A5);
        tick();
        idle();
        #1;
        check("wb9_cleared", 64'(busy_vec[9]), 64'h0);
        check("wb9_stored", 64'(rd_data[63:32]), 64'hA5A5A5A5);
        mark_en = 1; mark_addr = 9;
        tick();
        mark_en = 1; mark_addr = 9;
        wb_en = 1; wb_addr = 9; wb_data = 32'h00000077;
        #1;
        check("markwb_rdbusy", 64'(rd_busy[1]), 64'h1);
        tick();
        idle();
        #1;
        check("markwb_vec", 64'(busy_vec[9]), 64'h1);
        check("markwb_data", 64'(rd_data[63:32]), 64'h77);
        wa_en = 1; wa_addr = 9; wa_data = 32'h00000088;
        #1;
        check("waw_rdbusy", 64'(rd_busy[1]), 64'h1);
        tick();
        idle();
        #1;
        check("waw_vec", 64'(busy_vec), 64'h200);
        check("waw_data", 64'(rd_data[63:32]), 64'h88);

        // Collision on register 3: B data stored, one-cycle flag
        wa_en = 1; wa_addr = 3; wa_data = 32'h1111;
        wb_en = 1; wb_addr = 3; wb_data = 32'h2222;
        rd_addr[4:0] = 3;
        #1;
        check("coll_bypass", 64'(rd_data[31:0]), 64'h2222);
        tick();
        idle();
        #1;
        check("coll_flag", 64'(wr_collision), 64'h1);
        check("coll_data", 64'(rd_data[31:0]), 64'h2222);
        tick();
        check("coll_drop", 64'(wr_collision), 64'h0);

        // Parametric instance: reg 0 ordinary, four independent ports
        p_wa_en = 1; p_wa_addr = 0; p_wa_data = 16'hA0A0;
        p_wb_en = 1; p_wb_addr = 5; p_wb_data = 16'h5B5B;
        p_mark_en = 1; p_mark_addr = 0;
        tick();
        idle();
        p_wa_en = 1; p_wa_addr = 2; p_wa_data = 16'h2222;
        p_wb_en = 1; p_wb_addr = 7; p_wb_data = 16'h7777;
        tick();
        idle();
        p_rd_addr = {3'd7, 3'd5, 3'd2, 3'd0};
        #1;
        check("p_port0", 64'(p_rd_data[15:0]), 64'hA0A0);
        check("p_port1", 64'(p_rd_data[31:16]), 64'h2222);
        check("p_port2", 64'(p_rd_data[47:32]), 64'h5B5B);
        check("p_port3", 64'(p_rd_data[63:48]), 64'h7777);
        check("p_busyvec", 64'(p_busy_vec), 64'h01);
        check("p_rdbusy", 64'(p_rd_busy), 64'h1);
        p_wa_en = 1; p_wa_addr = 0; p_wa_data = 16'h0C0C;
        p_wb_en = 1; p_wb_addr = 0; p_wb_data = 16'h0D0D;
        #1;
        check("p_zero_bypass", 64'(p_rd_data[15:0]), 64'h0D0D);
        check("p_zero_rdbusy", 64'(p_rd_busy[0]), 64'h0);
        tick();
        idle();
        #1;
        check("p_zero_coll", 64'(p_wr_collision), 64'h1);
        check("p_zero_clr", 64'(p_busy_vec), 64'h00);
        check("p_zero_data", 64'(p_rd_data[15:0]), 64'h0D0D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
